// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divider control path: state encoding and the
// operand width shared with the multiplier sequencer.
package div_sequencer_pkg;

    localparam int DIV_WIDTH = 32;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t LOAD = 3'd1;
    localparam state_t ITER = 3'd2;
    localparam state_t DONE = 3'd3;
    localparam state_t ERR  = 3'd4;

    // A new request always lands in LOAD, or in ERR when the divisor is zero.
    function automatic state_t restart_target(input logic divisor_zero);
        return divisor_zero ? ERR : LOAD;
    endfunction

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the divider: async clear, synchronous clear (wins
// over enable) and a terminal-count flag at WIDTH-1.
module div_iter_counter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             clrn_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge clrn_i) begin
        if (!clrn_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/div_sequencer.sv
// Control FSM for the multicycle restoring divider: load, WIDTH
// shift/subtract iterations, then a one-cycle result (or exception) pulse.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ctrl_div,
    input  logic             divisor_zero,
    input  logic             diff_neg,
    output logic             qb_start,
    output logic             qb_ena,
    output logic             qb_shiftin,
    output logic             result_rdy,
    output logic             div_exception,
    output logic             busy,
    output logic [CNT_W-1:0] iter
);

    state_t state_q;
    state_t state_d;
    logic   cnt_clr;
    logic   cnt_en;
    logic   cnt_tc;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A request in any state aborts the current operation and restarts.
    always_comb begin
        state_d = state_q;
        if (ctrl_div) begin
            state_d = restart_target(divisor_zero);
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                LOAD:    state_d = ITER;
                ITER:    state_d = cnt_tc ? DONE : ITER;
                DONE:    state_d = IDLE;
                ERR:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        qb_start      = 1'b0;
        qb_ena        = 1'b0;
        qb_shiftin    = 1'b0;
        result_rdy    = 1'b0;
        div_exception = 1'b0;
        busy          = 1'b0;
        case (state_q)
            LOAD: begin
                qb_start = 1'b1;
                qb_ena   = 1'b1;
                busy     = 1'b1;
            end
            ITER: begin
                qb_ena     = 1'b1;
                qb_shiftin = ~diff_neg;
                busy       = 1'b1;
            end
            DONE: begin
                result_rdy = 1'b1;
                busy       = 1'b1;
            end
            ERR: begin
                result_rdy    = 1'b1;
                div_exception = 1'b1;
                busy          = 1'b1;
            end
            default: ;
        endcase
    end

    // Clearing on entry to LOAD makes iter read 0 in the LOAD cycle; enable
    // stops at terminal count so iter holds WIDTH-1 afterwards.
    assign cnt_clr = (state_d == LOAD);
    assign cnt_en  = (state_q == ITER) && !cnt_tc;

    div_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_i   (clk),
        .clrn_i  (clrn),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (iter),
        .tc_o    (cnt_tc)
    );

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural restoring-divider
// datapath driven by the sequencer's shift-block controls.
module tb_div_sequencer;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             clrn = 1'b0;
    logic             ctrl_div = 1'b0;
    logic             divisor_zero = 1'b0;
    logic             diff_neg;
    logic             qb_start;
    logic             qb_ena;
    logic             qb_shiftin;
    logic             result_rdy;
    logic             div_exception;
    logic             busy;
    logic [CNT_W-1:0] iter;

    div_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .clrn          (clrn),
        .ctrl_div      (ctrl_div),
        .divisor_zero  (divisor_zero),
        .diff_neg      (diff_neg),
        .qb_start      (qb_start),
        .qb_ena        (qb_ena),
        .qb_shiftin    (qb_shiftin),
        .result_rdy    (result_rdy),
        .div_exception (div_exception),
        .busy          (busy),
        .iter          (iter)
    );

    always #5 clk = ~clk;

    // Shift block: {remainder, quotient}, loaded with {0, dividend}.
    logic [31:0] rem_q = '0;
    logic [31:0] quo_q = '0;
    logic [31:0] dividend_r = '0;
    logic [31:0] divisor_r = 32'd1;
    logic        force_alt = 1'b0;
    logic [31:0] rem_sh;
    logic [32:0] diff;

    assign rem_sh   = {rem_q[30:0], quo_q[31]};
    assign diff     = {1'b0, rem_sh} - {1'b0, divisor_r};
    assign diff_neg = force_alt ? ~iter[0] : diff[32];

    always @(posedge clk) begin
        if (qb_ena) begin
            if (qb_start) begin
                rem_q <= '0;
                quo_q <= dividend_r;
            end else begin
                rem_q <= qb_shiftin ? diff[31:0] : rem_sh;
                quo_q <= {quo_q[30:0], qb_shiftin};
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] outs();
        return {qb_start, qb_ena, qb_shiftin, result_rdy, div_exception, busy};
    endfunction

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        dividend_r   = a;
        divisor_r    = b;
        divisor_zero = (b == 32'd0);
        ctrl_div     = 1'b1;
        tick();
        ctrl_div     = 1'b0;
        divisor_zero = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the ctrl_div edge; bounded by ncyc.
    task automatic observe(input int ncyc, output int n_start, output int n_ena,
                           output int n_rdy, output int first_rdy, output int n_busy,
                           output int last_busy, output int n_exc);
        n_start = 0; n_ena = 0; n_rdy = 0; first_rdy = -1;
        n_busy = 0; last_busy = -1; n_exc = 0;
        for (int c = 1; c <= ncyc; c++) begin
            if (qb_start) n_start++;
            if (qb_ena) n_ena++;
            if (div_exception) n_exc++;
            if (result_rdy) begin
                n_rdy++;
                if (first_rdy < 0) first_rdy = c;
            end
            if (busy) begin
                n_busy++;
                last_busy = c;
            end
            tick();
        end
    endtask

    initial begin
        int ns, ne, nr, fr, nb, lb, nx, mism;
        logic [5:0] acc_outs;
        logic [CNT_W-1:0] acc_iter;

        // Reset held for 3 cycles, then 10 idle cycles.
        repeat (3) tick();
        chk("reset_outs", 64'(outs()), 64'd0);
        chk("reset_iter", 64'(iter), 64'd0);
        clrn = 1'b1;
        acc_outs = '0;
        acc_iter = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            acc_outs |= outs();
            acc_iter |= iter;
        end
        chk("idle_outs", 64'(acc_outs), 64'd0);
        chk("idle_iter", 64'(acc_iter), 64'd0);

        // Normal division 100 / 7.
        start(32'd100, 32'd7);
        observe(40, ns, ne, nr, fr, nb, lb, nx);
        chk("norm_start_cycles", 64'(ns), 64'd1);
        chk("norm_ena_cycles", 64'(ne), 64'd33);
        chk("norm_rdy_count", 64'(nr), 64'd1);
        chk("norm_rdy_cycle", 64'(fr), 64'd34);
        chk("norm_busy_cycles", 64'(nb), 64'd34);
        chk("norm_busy_last", 64'(lb), 64'd34);
        chk("norm_exc", 64'(nx), 64'd0);
        chk("norm_quotient", 64'(quo_q), 64'd14);
        chk("norm_remainder", 64'(rem_q), 64'd2);
        chk("norm_iter_hold", 64'(iter), 64'd31);

        // Divide by zero.
        start(32'd9, 32'd0);
        chk("dz_rdy", 64'(result_rdy), 64'd1);
        chk("dz_exc", 64'(div_exception), 64'd1);
        chk("dz_ena", 64'(qb_ena), 64'd0);
        chk("dz_busy", 64'(busy), 64'd1);
        tick();
        chk("dz_idle_outs", 64'(outs()), 64'd0);

        // Restart at iteration 10 with 50 / 5.
        start(32'd100, 32'd7);
        repeat (11) tick();
        chk("rs_iter10", 64'(iter), 64'd10);
        chk("rs_mid_ena", 64'(qb_ena), 64'd1);
        start(32'd50, 32'd5);
        observe(40, ns, ne, nr, fr, nb, lb, nx);
        chk("rs_rdy_count", 64'(nr), 64'd1);
        chk("rs_rdy_cycle", 64'(fr), 64'd34);
        chk("rs_quotient", 64'(quo_q), 64'd10);
        chk("rs_remainder", 64'(rem_q), 64'd0);

        // Asynchronous reset during iteration 20.
        start(32'd100, 32'd7);
        repeat (21) tick();
        chk("ar_iter20", 64'(iter), 64'd20);
        #2 clrn = 1'b0;
        #1;
        chk("ar_outs_async", 64'(outs()), 64'd0);
        chk("ar_iter_async", 64'(iter), 64'd0);
        tick();
        tick();
        clrn = 1'b1;
        tick();
        chk("ar_post_outs", 64'(outs()), 64'd0);
        start(32'd7, 32'd7);
        observe(40, ns, ne, nr, fr, nb, lb, nx);
        chk("ar_rdy_cycle", 64'(fr), 64'd34);
        chk("ar_quotient", 64'(quo_q), 64'd1);
        chk("ar_remainder", 64'(rem_q), 64'd0);

        // Forced alternating diff_neg during ITER.
        force_alt = 1'b1;
        start(32'hDEADBEEF, 32'd3);
        tick();
        mism = 0;
        for (int k = 0; k < WIDTH; k++) begin
            if (qb_shiftin !== k[0]) mism++;
            if (qb_shiftin !== ~diff_neg) mism++;
            tick();
        end
        chk("pol_shiftin_mismatches", 64'(mism), 64'd0);
        chk("pol_rdy", 64'(result_rdy), 64'd1);
        chk("pol_quotient", 64'(quo_q), 64'h5555_5555);
        force_alt = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
